// File: rtl/exec_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
// Signal names keep their direction suffix as seen from the load/store unit.
interface exec_lsu_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) ();
   logic                mem_req_out;
   logic                mem_we_out;
   logic [ADDR_W-1:0]   mem_addr_out;
   logic [XLEN-1:0]     mem_wdata_out;
   logic [XLEN/8-1:0]   mem_strb_out;
   logic                mem_gnt_in;
   logic                mem_rvalid_in;
   logic [XLEN-1:0]     mem_rdata_in;
   logic                mem_err_in;

   modport master (
      output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_strb_out,
      input  mem_gnt_in, mem_rvalid_in, mem_rdata_in, mem_err_in
   );

   modport slave (
      input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_strb_out,
      output mem_gnt_in, mem_rvalid_in, mem_rdata_in, mem_err_in
   );
endinterface

// File: rtl/exec_lsu.sv
// Multi-cycle load/store unit: lane alignment, load extension and a req/gnt/rvalid bus master.
// Every output is registered; lsu_busy_out stalls the pipeline for the whole access.
module exec_lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lsu_req_in,
   input  logic             lsu_we_in,
   input  logic [2:0]       lsu_func3_in,
   input  logic [XLEN-1:0]  lsu_base_in,
   input  logic [XLEN-1:0]  lsu_offset_in,
   input  logic [XLEN-1:0]  lsu_store_data_in,
   input  logic [4:0]       lsu_rd_in,
   input  logic             lsu_flush_in,
   output logic             lsu_busy_out,
   output logic             lsu_done_out,
   output logic             lsu_wen_out,
   output logic [4:0]       lsu_write_addr_out,
   output logic [XLEN-1:0]  lsu_write_data_out,
   output logic [1:0]       lsu_exc_out,
   output logic [XLEN-1:0]  lsu_exc_addr_out,
   exec_lsu_if.master       mem
);
   localparam int unsigned STRB_W = XLEN / 8;
   localparam int unsigned OFS_W  = $clog2(STRB_W);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     ea_q, ea_d, ea_new;
   logic                we_q, we_d, squash_q, squash_d, sq;
   logic [2:0]          f3_q, f3_d;
   logic [4:0]          rd_q, rd_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                busy_q, done_q, done_d, wen_q, wen_d;
   logic [4:0]          waddr_q, waddr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d, exc_addr_q, exc_addr_d;
   logic [1:0]          exc_q, exc_d;
   logic                mreq_q, mreq_d, mwe_q, mwe_d;
   logic [ADDR_W-1:0]   maddr_q, maddr_d;
   logic [XLEN-1:0]     mwdata_q, mwdata_d, st_wdata, ld_shift, ld_ext;
   logic [STRB_W-1:0]   mstrb_q, mstrb_d, st_strb;
   logic [OFS_W-1:0]    sh_new;
   logic                bad_op, misaligned;

   // Request decode: effective address, legality and store lane placement.
   always_comb begin
      ea_new = lsu_base_in + lsu_offset_in;
      sh_new = ea_new[OFS_W-1:0];
      if (lsu_we_in) begin
         bad_op = lsu_func3_in[2] || ((lsu_func3_in[1:0] == 2'b11) && (XLEN != 64));
      end else begin
         bad_op = (lsu_func3_in == 3'b111) ||
                  (((lsu_func3_in == 3'b011) || (lsu_func3_in == 3'b110)) && (XLEN != 64));
      end
      case (lsu_func3_in[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = ea_new[0];
         2'b10:   misaligned = |ea_new[1:0];
         default: misaligned = |ea_new[2:0];
      endcase
      case (lsu_func3_in[1:0])
         2'b00: begin
            st_wdata = {STRB_W{lsu_store_data_in[7:0]}};
            st_strb  = STRB_W'(1) << sh_new;
         end
         2'b01: begin
            st_wdata = {(STRB_W/2){lsu_store_data_in[15:0]}};
            st_strb  = STRB_W'(3) << sh_new;
         end
         2'b10: begin
            st_wdata = {(STRB_W/4){lsu_store_data_in[31:0]}};
            st_strb  = STRB_W'(4'hF) << sh_new;
         end
         default: begin
            st_wdata = lsu_store_data_in;
            st_strb  = '1;
         end
      endcase
      if (!lsu_we_in) st_strb = '1;
   end

   always_comb begin
      ld_shift = mem.mem_rdata_in >> {ea_q[OFS_W-1:0], 3'b000};
      case (f3_q)
         3'b000:  ld_ext = XLEN'($signed(ld_shift[7:0]));
         3'b001:  ld_ext = XLEN'($signed(ld_shift[15:0]));
         3'b010:  ld_ext = XLEN'($signed(ld_shift[31:0]));
         3'b100:  ld_ext = XLEN'(ld_shift[7:0]);
         3'b101:  ld_ext = XLEN'(ld_shift[15:0]);
         3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
         default: ld_ext = ld_shift;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ea_d       = ea_q;
      we_d       = we_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      squash_d   = squash_q;
      sq         = squash_q | lsu_flush_in;
      done_d     = 1'b0;
      wen_d      = 1'b0;
      waddr_d    = '0;
      wdata_d    = '0;
      exc_d      = 2'b00;
      exc_addr_d = '0;
      mreq_d     = 1'b0;
      mwe_d      = 1'b0;
      maddr_d    = '0;
      mwdata_d   = '0;
      mstrb_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (lsu_req_in) begin
               ea_d     = ea_new;
               we_d     = lsu_we_in;
               f3_d     = lsu_func3_in;
               rd_d     = lsu_rd_in;
               cnt_d    = '0;
               squash_d = 1'b0;
               if (bad_op || misaligned) begin
                  state_d    = StDone;
                  done_d     = 1'b1;
                  waddr_d    = lsu_rd_in;
                  exc_d      = 2'b01;
                  exc_addr_d = ea_new;
               end else begin
                  state_d  = StReq;
                  mreq_d   = 1'b1;
                  mwe_d    = lsu_we_in;
                  maddr_d  = {ea_new[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                  mwdata_d = lsu_we_in ? st_wdata : '0;
                  mstrb_d  = st_strb;
               end
            end
         end
         StReq: begin
            // A grant in the same cycle as a flush is already accepted by the bus.
            if (mem.mem_gnt_in) begin
               state_d  = StWait;
               cnt_d    = '0;
               squash_d = lsu_flush_in;
            end else if (lsu_flush_in) begin
               state_d = StIdle;
            end else begin
               mreq_d   = 1'b1;
               mwe_d    = mwe_q;
               maddr_d  = maddr_q;
               mwdata_d = mwdata_q;
               mstrb_d  = mstrb_q;
            end
         end
         StWait: begin
            cnt_d    = cnt_q + 32'd1;
            squash_d = sq;
            if (mem.mem_rvalid_in) begin
               state_d = StDone;
               done_d  = 1'b1;
               waddr_d = rd_q;
               if (!sq && mem.mem_err_in) begin
                  exc_d      = 2'b10;
                  exc_addr_d = ea_q;
               end else if (!sq && !we_q && (rd_q != 5'd0)) begin
                  wen_d   = 1'b1;
                  wdata_d = ld_ext;
               end
            end else if ((TIMEOUT != 0) && ((cnt_q + 32'd1) >= TIMEOUT)) begin
               state_d = StDone;
               done_d  = 1'b1;
               waddr_d = rd_q;
               if (!sq) begin
                  exc_d      = 2'b11;
                  exc_addr_d = ea_q;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ea_q       <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         squash_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         exc_q      <= '0;
         exc_addr_q <= '0;
         mreq_q     <= 1'b0;
         mwe_q      <= 1'b0;
         maddr_q    <= '0;
         mwdata_q   <= '0;
         mstrb_q    <= '0;
      end else begin
         state_q    <= state_d;
         ea_q       <= ea_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         squash_q   <= squash_d;
         busy_q     <= (state_d != StIdle);
         done_q     <= done_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         exc_q      <= exc_d;
         exc_addr_q <= exc_addr_d;
         mreq_q     <= mreq_d;
         mwe_q      <= mwe_d;
         maddr_q    <= maddr_d;
         mwdata_q   <= mwdata_d;
         mstrb_q    <= mstrb_d;
      end
   end

   assign lsu_busy_out       = busy_q;
   assign lsu_done_out       = done_q;
   assign lsu_wen_out        = wen_q;
   assign lsu_write_addr_out = waddr_q;
   assign lsu_write_data_out = wdata_q;
   assign lsu_exc_out        = exc_q;
   assign lsu_exc_addr_out   = exc_addr_q;
   assign mem.mem_req_out    = mreq_q;
   assign mem.mem_we_out     = mwe_q;
   assign mem.mem_addr_out   = maddr_q;
   assign mem.mem_wdata_out  = mwdata_q;
   assign mem.mem_strb_out   = mstrb_q;
endmodule
